// File: rtl/display_mux.sv
`default_nettype none
// ============================================================================
//  Module      : display_mux
//  Description : Time-multiplexes two hex digits onto a shared, active-low
//                seven-segment bus.  Each toggle of clk_div requests a swap
//                between the two displays.  Every swap passes through a
//                blanking interval of BLANK_CYCLES clocks with both displays
//                off, so a digit never ghosts onto the other display.
//  Ports       : clk      - system clock, rising-edge active
//                reset    - synchronous reset, active-low
//                clk_div  - divided-clock level; each edge requests a swap
//                s0, s1   - hex digits for display 0 / display 1
//                seg      - shared segments {g,f,e,d,c,b,a}, active-low
//                an0, an1 - display enables, active-low, never both low
//  Revision    : 1.0 - initial release
// ============================================================================
module display_mux #(
    parameter int BLANK_CYCLES = 4      // legal range 1..255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_div,
    input  logic [3:0] s0,
    input  logic [3:0] s1,
    output logic [6:0] seg,
    output logic       an0,
    output logic       an1
);

    localparam logic [7:0] BLANK_LOAD = 8'(BLANK_CYCLES);
    localparam logic [6:0] SEG_OFF    = 7'b111_1111;

    typedef enum logic [1:0] {
        SHOW0   = 2'd0,
        BLANK01 = 2'd1,
        SHOW1   = 2'd2,
        BLANK10 = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q,   cnt_d;
    logic [3:0] dig0_q,  dig0_d;
    logic [3:0] dig1_q,  dig1_d;
    logic       clk_div_q;
    logic [6:0] seg_q,   seg_d;
    logic       an0_q,   an0_d;
    logic       an1_q,   an1_d;
    logic       tick;

    // Active-low hex glyphs, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_decode(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'h0:    g = 7'b100_0000;
            4'h1:    g = 7'b111_1001;
            4'h2:    g = 7'b010_0100;
            4'h3:    g = 7'b011_0000;
            4'h4:    g = 7'b001_1001;
            4'h5:    g = 7'b001_0010;
            4'h6:    g = 7'b000_0010;
            4'h7:    g = 7'b111_1000;
            4'h8:    g = 7'b000_0000;
            4'h9:    g = 7'b001_0000;
            4'hA:    g = 7'b000_1000;
            4'hB:    g = 7'b000_0011;
            4'hC:    g = 7'b100_0110;
            4'hD:    g = 7'b010_0001;
            4'hE:    g = 7'b000_0110;
            default: g = 7'b000_1110;
        endcase
        return g;
    endfunction

    // clk_div already lives in this clock domain, so a one-cycle delayed
    // copy is enough to detect both edges.
    assign tick = (clk_div != clk_div_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dig0_d  = dig0_q;
        dig1_d  = dig1_q;

        case (state_q)
            SHOW0: begin
                if (tick) begin
                    state_d = BLANK01;
                    cnt_d   = BLANK_LOAD;
                end
            end
            SHOW1: begin
                if (tick) begin
                    state_d = BLANK10;
                    cnt_d   = BLANK_LOAD;
                end
            end
            // Ticks are deliberately not looked at while blanking; a swap
            // request that lands here is simply dropped.  The <= 1 compare
            // also covers a (never expected) zero count.
            BLANK01: begin
                if (cnt_q <= 8'd1) begin
                    state_d = SHOW1;
                    dig1_d  = s1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            BLANK10: begin
                if (cnt_q <= 8'd1) begin
                    state_d = SHOW0;
                    dig0_d  = s0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = BLANK10;
                cnt_d   = BLANK_LOAD;
            end
        endcase

        // Outputs are derived from the next state so the registered outputs
        // change on the same edge as the state itself.
        seg_d = SEG_OFF;
        an0_d = 1'b1;
        an1_d = 1'b1;
        case (state_d)
            SHOW0: begin
                an0_d = 1'b0;
                seg_d = hex_decode(dig0_d);
            end
            SHOW1: begin
                an1_d = 1'b0;
                seg_d = hex_decode(dig1_d);
            end
            default: begin
                seg_d = SEG_OFF;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // Tracks clk_div even in reset, so no spurious tick after release.
        clk_div_q <= clk_div;
        if (!reset) begin
            state_q <= BLANK10;
            cnt_q   <= BLANK_LOAD;
            dig0_q  <= 4'h0;
            dig1_q  <= 4'h0;
            seg_q   <= SEG_OFF;
            an0_q   <= 1'b1;
            an1_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dig0_q  <= dig0_d;
            dig1_q  <= dig1_d;
            seg_q   <= seg_d;
            an0_q   <= an0_d;
            an1_q   <= an1_d;
        end
    end

    assign seg = seg_q;
    assign an0 = an0_q;
    assign an1 = an1_q;

endmodule
`default_nettype wire

// File: tb/tb_display_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_display_mux
//  Description : Directed self-checking bench for display_mux with
//                BLANK_CYCLES = 4.  Observed value is {an1, an0, seg}.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_display_mux;

    localparam int BLANK_CYCLES = 4;

    logic       clk;
    logic       reset;
    logic       clk_div;
    logic [3:0] s0;
    logic [3:0] s1;
    logic [6:0] seg;
    logic       an0;
    logic       an1;

    int n_total;
    int n_bad;
    bit armed;

    display_mux #(.BLANK_CYCLES(BLANK_CYCLES)) u_dut (
        .clk     (clk),
        .reset   (reset),
        .clk_div (clk_div),
        .s0      (s0),
        .s1      (s1),
        .seg     (seg),
        .an0     (an0),
        .an1     (an1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-written active-low glyph table {g,f,e,d,c,b,a}.
    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [8:0] exp_show0(input logic [3:0] d);
        return {1'b1, 1'b0, glyph(d)};
    endfunction

    function automatic logic [8:0] exp_show1(input logic [3:0] d);
        return {1'b0, 1'b1, glyph(d)};
    endfunction

    localparam logic [8:0] EXP_BLANK = 9'h1FF;

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] obs();
        return {an1, an0, seg};
    endfunction

    // Advance one rising edge and settle before sampling / driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Toggle clk_div and verify the whole blank interval plus the new display.
    task automatic swap(input string tag, input logic [8:0] exp_after);
        clk_div = ~clk_div;
        for (int k = 0; k < BLANK_CYCLES; k++) begin
            step();
            check({tag, "_blank"}, obs(), EXP_BLANK);
        end
        step();
        check({tag, "_show"}, obs(), exp_after);
    endtask

    task automatic hold(input string tag, input int n, input logic [8:0] exp);
        for (int k = 0; k < n; k++) begin
            step();
            check(tag, obs(), exp);
        end
    endtask

    // Both enables low at once is never legal.
    always @(negedge clk) begin
        if (armed) check("one_anode", {8'h00, an0 | an1}, 9'h001);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_total = 0;
        n_bad   = 0;
        armed   = 1'b0;
        reset   = 1'b0;
        clk_div = 1'b0;
        s0      = 4'h0;
        s1      = 4'h1;

        // Reset held for three edges.
        for (int k = 0; k < 3; k++) begin
            step();
            armed = 1'b1;
            check("reset_blank", obs(), EXP_BLANK);
        end
        reset = 1'b1;
        hold("post_reset_blank", BLANK_CYCLES - 1, EXP_BLANK);
        step();
        check("first_show0", obs(), exp_show0(4'h0));
        hold("show0_hold", 3, exp_show0(4'h0));

        // Rising then falling toggle.
        swap("rise", exp_show1(4'h1));
        hold("show1_hold", 3, exp_show1(4'h1));
        swap("fall", exp_show0(4'h0));

        // Digit changes are latched only on entry.
        s0 = 4'h8;
        hold("s0_not_latched", 2, exp_show0(4'h0));
        swap("to1_a", exp_show1(4'h1));
        swap("to0_8", exp_show0(4'h8));
        s0 = 4'hF;
        hold("s0_held_8", 3, exp_show0(4'h8));
        swap("to1_b", exp_show1(4'h1));
        swap("to0_F", exp_show0(4'hF));

        // Second toggle inside BLANK01 is dropped.
        clk_div = ~clk_div;
        step();
        check("dbl_blank0", obs(), EXP_BLANK);
        clk_div = ~clk_div;
        hold("dbl_blank", BLANK_CYCLES - 1, EXP_BLANK);
        step();
        check("dbl_show1", obs(), exp_show1(4'h1));
        hold("dbl_no_extra", 2 * BLANK_CYCLES + 2, exp_show1(4'h1));

        // Reset one cycle into SHOW1 while clk_div toggles.
        swap("pre_rst0", exp_show0(4'hF));
        swap("pre_rst1", exp_show1(4'h1));
        step();
        check("rst_show1_prev", obs(), exp_show1(4'h1));
        reset   = 1'b0;
        clk_div = ~clk_div;
        step();
        check("rst_mid_show", obs(), EXP_BLANK);
        reset = 1'b1;
        hold("rst_show_rel", BLANK_CYCLES - 1, EXP_BLANK);
        step();
        check("rst_show_to0", obs(), exp_show0(4'hF));
        hold("rst_show_hold", 3, exp_show0(4'hF));

        // Reset mid-BLANK01 returns toward SHOW0, not SHOW1.
        clk_div = ~clk_div;
        step();
        check("rstb_blank0", obs(), EXP_BLANK);
        step();
        check("rstb_blank1", obs(), EXP_BLANK);
        reset = 1'b0;
        step();
        check("rstb_in_rst", obs(), EXP_BLANK);
        reset = 1'b1;
        hold("rstb_rel", BLANK_CYCLES - 1, EXP_BLANK);
        step();
        check("rstb_to0", obs(), exp_show0(4'hF));

        // Sweep every code through both displays.
        for (int i = 0; i < 16; i++) begin
            s0 = 4'(i);
            s1 = 4'((i + 5) & 15);
            swap("sweep1", exp_show1(4'((i + 5) & 15)));
            swap("sweep0", exp_show0(4'(i)));
        end

        armed = 1'b0;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
